// File: rtl/riscv_mem_stage_pkg.sv
// riscv_mem_stage_pkg: shared widths, funct3 codes, FSM states and alignment helper for the MEM stage
package riscv_mem_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LH = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;
  // funct3[1:0] carries the access size; any non-byte, non-half code is a word access
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == SZ_H) ? a[0] : (f3[1:0] != SZ_B) & (a != 2'b00);
  endfunction
endpackage

// File: rtl/riscv_mem_stage_lsu_align.sv
// riscv_lsu_align: byte-enable/store-lane replication and load lane select with extension
module riscv_lsu_align
  import riscv_mem_stage_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_ld_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  // store lanes replicate the narrow datum so the enabled lane always holds it
  always_comb begin
    o_be = (i_funct3[1:0] == SZ_B) ? 4'b0001 << i_addr :
           (i_funct3[1:0] == SZ_H) ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
    o_wdata = (i_funct3[1:0] == SZ_B) ? {4{i_wdata[7:0]}} :
              (i_funct3[1:0] == SZ_H) ? {2{i_wdata[15:0]}} : i_wdata;
    w_byte = 8'(i_rdata >> {i_addr, 3'b000});
    w_half = 16'(i_rdata >> {i_addr[1], 4'b0000});
    o_ld_data = (i_funct3 == F3_LB)  ? {{(XLEN-8){w_byte[7]}}, w_byte} :
                (i_funct3 == F3_LH)  ? {{(XLEN-16){w_half[15]}}, w_half} :
                (i_funct3 == F3_LBU) ? {{(XLEN-8){1'b0}}, w_byte} :
                (i_funct3 == F3_LHU) ? {{(XLEN-16){1'b0}}, w_half} : i_rdata;
  end
endmodule

// File: rtl/riscv_mem_stage.sv
// riscv_mem_stage: data-memory access FSM, timeout watchdog and MEM/WB pipeline register
module riscv_mem_stage
  import riscv_mem_stage_pkg::*;
#(
  parameter int P_MAX_WAIT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_MEM_valid,
  input  logic            i_MEM_reg_wr_en,
  input  logic [1:0]      i_MEM_src_rd,
  input  logic            i_MEM_mem_rd_en,
  input  logic            i_MEM_mem_wr_en,
  input  logic [2:0]      i_MEM_funct3,
  input  logic [XLEN-1:0] i_MEM_alu_out,
  input  logic [XLEN-1:0] i_MEM_rs2_data,
  input  logic [XLEN-1:0] i_MEM_pc4,
  input  logic [XLEN-1:0] i_MEM_imm,
  input  logic [4:0]      i_MEM_rd,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_MEM_stall,
  output logic            o_MEM_misalign,
  output logic            o_MEM_bus_err,
  output logic            o_WB_reg_wr_en,
  output logic [1:0]      o_WB_src_rd,
  output logic [XLEN-1:0] o_WB_alu_out,
  output logic [XLEN-1:0] o_WB_mem_rd_data,
  output logic [XLEN-1:0] o_WB_pc4,
  output logic [XLEN-1:0] o_WB_imm,
  output logic [4:0]      o_WB_rd
);
  localparam int CW = $clog2(P_MAX_WAIT + 1);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_mem_op, w_store, w_mis, w_req, w_timeout, w_done, w_err;
  logic [XLEN-1:0] w_ld_data;
  logic            r_misalign, r_bus_err, r_wb_reg_wr_en;
  logic [1:0]      r_wb_src_rd;
  logic [XLEN-1:0] r_wb_alu_out, r_wb_mem_rd_data, r_wb_pc4, r_wb_imm;
  logic [4:0]      r_wb_rd;

  assign w_mem_op = i_MEM_valid & (i_MEM_mem_rd_en | i_MEM_mem_wr_en);
  assign w_store = i_MEM_mem_wr_en;

  riscv_lsu_align u_align (
    .i_funct3  (i_MEM_funct3),
    .i_addr    (i_MEM_alu_out[1:0]),
    .i_wdata   (i_MEM_rs2_data),
    .i_rdata   (i_dmem_rdata),
    .o_be      (o_dmem_be),
    .o_wdata   (o_dmem_wdata),
    .o_ld_data (w_ld_data)
  );

  // state and wait counter; counter restarts whenever REQ or WAIT is (re)entered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next == S_IDLE || w_next != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  // a misaligned or timed-out op is dropped rather than stalled so upstream can trap
  always_comb begin
    w_mis = (r_state == S_IDLE) & w_mem_op & misaligned(i_MEM_funct3, i_MEM_alu_out[1:0]);
    w_req = ~i_rst & (((r_state == S_IDLE) & w_mem_op & ~w_mis) | (r_state == S_REQ));
    w_timeout = (r_state != S_IDLE) & (r_cnt == CW'(P_MAX_WAIT - 1));
    w_done = ((r_state == S_IDLE) & i_MEM_valid & ~w_mem_op) | (w_req & i_dmem_gnt & w_store) |
             ((r_state == S_WAIT) & i_dmem_rvalid);
    w_err = w_timeout & ~w_done & ~(w_req & i_dmem_gnt);
    o_MEM_stall = w_mem_op & ~w_done & ~w_mis & ~w_err;
    o_dmem_req = w_req;
    o_dmem_we = w_req & w_store;
    o_dmem_addr = {i_MEM_alu_out[XLEN-1:2], 2'b00};
  end

  // gnt moves a store to done and a load to WAIT; rvalid only counts in WAIT
  always_comb begin
    w_next = (w_err | ((r_state == S_WAIT) & i_dmem_rvalid)) ? S_IDLE :
             w_req ? (i_dmem_gnt ? (w_store ? S_IDLE : S_WAIT) : S_REQ) :
             (r_state == S_WAIT) ? S_WAIT : S_IDLE;
  end

  // MEM/WB register: load bundle on completion, otherwise insert a bubble and hold the data fields
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_misalign <= 1'b0;
      r_bus_err <= 1'b0;
      r_wb_reg_wr_en <= 1'b0;
      r_wb_src_rd <= '0;
      r_wb_alu_out <= '0;
      r_wb_mem_rd_data <= '0;
      r_wb_pc4 <= '0;
      r_wb_imm <= '0;
      r_wb_rd <= '0;
    end else begin
      r_misalign <= w_mis;
      r_bus_err <= w_err;
      r_wb_reg_wr_en <= w_done & i_MEM_reg_wr_en;
      if (w_done) begin
        r_wb_src_rd <= i_MEM_src_rd;
        r_wb_alu_out <= i_MEM_alu_out;
        r_wb_mem_rd_data <= w_ld_data;
        r_wb_pc4 <= i_MEM_pc4;
        r_wb_imm <= i_MEM_imm;
        r_wb_rd <= i_MEM_rd;
      end
    end
  end

  assign o_MEM_misalign = r_misalign;
  assign o_MEM_bus_err = r_bus_err;
  assign o_WB_reg_wr_en = r_wb_reg_wr_en;
  assign o_WB_src_rd = r_wb_src_rd;
  assign o_WB_alu_out = r_wb_alu_out;
  assign o_WB_mem_rd_data = r_wb_mem_rd_data;
  assign o_WB_pc4 = r_wb_pc4;
  assign o_WB_imm = r_wb_imm;
  assign o_WB_rd = r_wb_rd;
endmodule
